// File: rtl/mips_pkg.sv
// Shared constants for the fetch front end: word width, NOP encoding and the default reset PC.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with synchronous push, pop and flush.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A full buffer can still accept a push when the head leaves in the same cycle.
  assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: credit-limited in-order prefetch into a small buffer, with branch
// redirect that flushes the buffer and discards responses still in flight.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              stall,
  output logic [WORD_W-1:0] next_instruction,
  output logic [WORD_W-1:0] pc_plus_4,
  output logic              inst_valid
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * WORD_W;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] resp_pc;
  logic [WORD_W-1:0] redirect_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard_count;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic [EW-1:0]     head;
  logic              fifo_empty;
  logic              accept;
  logic              drop;
  logic              kept;
  logic              pop;

  assign redirect_pc = word_align(branch_target);
  // In-flight requests plus buffered words may never exceed the buffer size.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req    = reset && !branch_taken && (credit_used < CREDIT_LIMIT);
  assign imem_addr   = pc;
  assign accept      = imem_req && imem_ready;
  assign drop        = imem_rvalid && (branch_taken || (discard_count != '0));
  assign kept        = imem_rvalid && !drop;
  assign pop         = !fifo_empty && !stall && !branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (branch_taken) begin
      pc      <= redirect_pc;
      resp_pc <= redirect_pc;
    end else begin
      if (accept) pc      <= pc + 32'd4;
      if (kept)   resp_pc <= resp_pc + 32'd4;
    end
  end

  // Outstanding counts every request in flight, including ones already marked for discard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding   <= '0;
      discard_count <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (branch_taken)
        discard_count <= outstanding - CW'(imem_rvalid);
      else if (imem_rvalid && (discard_count != '0))
        discard_count <= discard_count - 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (kept),
    .push_data ({imem_rdata, resp_pc + 32'd4}),
    .pop       (pop),
    .flush     (branch_taken),
    .head_data (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign inst_valid       = !fifo_empty;
  assign next_instruction = fifo_empty ? NOP_WORD : head[EW-1:WORD_W];
  assign pc_plus_4        = fifo_empty ? '0 : head[WORD_W-1:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model, in-order memory with variable
// latency, and directed scenarios for stall, redirect, reset and PC wrap.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ready, branch_taken, stall, inst_valid;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] imem_addr, branch_target, next_instruction, pc_plus_4;
  logic        w_req, w_valid;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic [31:0] w_addr, w_instr, w_pc4;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .next_instruction(next_instruction), .pc_plus_4(pc_plus_4), .inst_valid(inst_valid)
  );

  instruction_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .branch_taken(1'b0), .branch_target(32'h0), .stall(1'b0),
    .next_instruction(w_instr), .pc_plus_4(w_pc4), .inst_valid(w_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] addr; bit drop; } infl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; int c; } dlog_t;

  mreq_t memq[$];
  mreq_t alog[$];
  dlog_t dlog[$];
  infl_t infl[$];
  ent_t  mfifo[$];
  logic [31:0] mpc = 32'h0;
  bit    m_exp_req, m_keep;
  infl_t m_arr;

  // In-order memory: each accepted request answers lat cycles later, one per cycle.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (!reset) memq.delete();
    else if (memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end
  end

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", inst_valid, 1'b0);
      chk("rst_instr", next_instruction, 32'h0);
      chk("rst_pc4", pc_plus_4, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      infl.delete();
      mfifo.delete();
      mpc = 32'h0;
    end else begin
      m_exp_req = !branch_taken && (infl.size() + mfifo.size() < DEPTH);
      chk1("req", imem_req, m_exp_req);
      chk("addr", imem_addr, mpc);
      chk1("valid", inst_valid, mfifo.size() != 0);
      if (mfifo.size() != 0) begin
        chk("instr", next_instruction, mfifo[0].instr);
        chk("pc4", pc_plus_4, mfifo[0].pc4);
      end else begin
        chk("nop_instr", next_instruction, 32'h0);
        chk("nop_pc4", pc_plus_4, 32'h0);
      end
      if (imem_req && imem_ready) begin
        memq.push_back('{addr: imem_addr, due: cyc + lat});
        alog.push_back('{addr: imem_addr, due: cyc});
      end
      if (inst_valid && !stall && !branch_taken)
        dlog.push_back('{instr: next_instruction, pc4: pc_plus_4, c: cyc});
      m_keep = 1'b0;
      if (imem_rvalid && infl.size() != 0) begin
        m_arr  = infl.pop_front();
        m_keep = !branch_taken && !m_arr.drop;
      end
      if (branch_taken) begin
        mfifo.delete();
        foreach (infl[i]) infl[i].drop = 1'b1;
        mpc = {branch_target[31:2], 2'b00};
      end else begin
        if (mfifo.size() != 0 && !stall) void'(mfifo.pop_front());
        if (m_exp_req && imem_ready) begin
          infl.push_back('{addr: mpc, drop: 1'b0});
          mpc = mpc + 32'd4;
        end
      end
      if (m_keep) mfifo.push_back('{instr: mem_word(m_arr.addr), pc4: m_arr.addr + 32'd4});
    end
  end

  // One-cycle memory for the wrap-around instance, plus logs of its first transactions.
  logic        w_acc_q = 1'b0;
  logic [31:0] w_addr_q = '0;
  logic [31:0] w_alog[$];
  logic [31:0] w_pc4_log[$];
  logic [31:0] w_instr_log[$];
  always @(negedge clk) begin
    w_rvalid = reset && w_acc_q;
    w_rdata  = mem_word(w_addr_q);
    #2;
    if (!reset) w_acc_q = 1'b0;
    else begin
      w_acc_q  = w_req;
      w_addr_q = w_addr;
      if (w_req) w_alog.push_back(w_addr);
      if (w_valid) begin
        w_pc4_log.push_back(w_pc4);
        w_instr_log.push_back(w_instr);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, k, rc;
    logic [31:0] held_instr, held_pc4;
    imem_ready = 1'b1; branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
    repeat (3) tick();

    // Free-running fetch with a 1-cycle memory.
    reset = 1'b1;
    repeat (12) tick();
    if (alog.size() >= 3 && dlog.size() >= 3) begin
      chk("p1_addr0", alog[0].addr, 32'h0);
      chk("p1_addr1", alog[1].addr, 32'h4);
      chk("p1_addr2", alog[2].addr, 32'h8);
      chk("p1_latency", dlog[0].c - alog[0].due, 32'd2);
      chk("p1_pc4_0", dlog[0].pc4, 32'h4);
      chk("p1_pc4_1", dlog[1].pc4, 32'h8);
      chk("p1_pc4_2", dlog[2].pc4, 32'hC);
      chk("p1_instr0", dlog[0].instr, 32'hDEAD_BEEF);
    end else chk("p1_counts", alog.size() + dlog.size(), 32'd6);

    // Memory back-pressure with a 2-cycle memory.
    lat = 2;
    for (int i = 0; i < 15; i++) begin
      imem_ready = (i % 3) != 1;
      tick();
    end
    imem_ready = 1'b1;
    lat = 1;
    repeat (4) tick();

    // Stall until the buffer is full, hold 5 cycles, then release.
    stall = 1'b1;
    for (k = 0; k < 40 && !(mfifo.size() == DEPTH && infl.size() == 0); k++) tick();
    chk1("p3_fill_timeout", k < 40, 1'b1);
    held_instr = mfifo.size() != 0 ? mfifo[0].instr : 32'h0;
    held_pc4   = mfifo.size() != 0 ? mfifo[0].pc4 : 32'h0;
    d0 = dlog.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      chk1("p3_stall_req", imem_req, 1'b0);
      chk1("p3_stall_valid", inst_valid, 1'b1);
      chk("p3_stall_hold", next_instruction, held_instr);
    end
    tick();
    stall = 1'b0;
    repeat (10) tick();
    if (dlog.size() >= d0 + 4) begin
      chk("p3_first_after", dlog[d0].pc4, held_pc4);
      for (int i = d0 + 1; i < dlog.size(); i++) begin
        chk("p3_seq_pc4", dlog[i].pc4, dlog[i-1].pc4 + 32'd4);
        chk("p3_seq_instr", dlog[i].instr, mem_word(dlog[i].pc4 - 32'd4));
      end
    end else chk("p3_delivered", dlog.size() - d0, 32'd4);

    // Redirect to an unaligned target while two requests are outstanding.
    lat = 3;
    for (k = 0; k < 40 && memq.size() != 2; k++) tick();
    chk1("p4_outstanding_timeout", k < 40, 1'b1);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    a0 = alog.size();
    d0 = dlog.size();
    tick();
    branch_taken = 1'b0;
    repeat (12) tick();
    if (alog.size() > a0 && dlog.size() > d0) begin
      chk("p4_redirect_addr", alog[a0].addr, 32'h100);
      chk("p4_first_pc4", dlog[d0].pc4, 32'h104);
      chk("p4_first_instr", dlog[d0].instr, 32'hDEAD_BFEF);
    end else chk("p4_counts", alog.size() - a0 + dlog.size() - d0, 32'd2);

    // Branch and stall together with a non-empty buffer.
    lat = 1;
    for (k = 0; k < 40 && mfifo.size() == 0; k++) tick();
    chk1("p5_fill_timeout", k < 40, 1'b1);
    branch_taken = 1'b1;
    stall = 1'b1;
    branch_target = 32'h0000_0200;
    tick();
    branch_taken = 1'b0;
    stall = 1'b0;
    #2;
    chk1("p5_flush_valid", inst_valid, 1'b0);
    repeat (8) tick();

    // Asynchronous reset mid-stream with a full buffer.
    stall = 1'b1;
    for (k = 0; k < 40 && mfifo.size() != DEPTH; k++) tick();
    chk1("p6_fill_timeout", k < 40, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk1("p6_async_valid", inst_valid, 1'b0);
    chk1("p6_async_req", imem_req, 1'b0);
    chk("p6_async_instr", next_instruction, 32'h0);
    chk("p6_async_pc4", pc_plus_4, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    stall = 1'b0;
    rc = cyc;
    a0 = alog.size();
    repeat (6) tick();
    if (alog.size() >= a0 + 2) begin
      chk("p6_restart_addr0", alog[a0].addr, 32'h0);
      chk("p6_restart_addr1", alog[a0+1].addr, 32'h4);
      chk("p6_restart_cycle", alog[a0].due, rc);
    end else chk("p6_accept_count", alog.size(), a0 + 2);

    // PC wrap on the second instance (captured during the first run after reset).
    if (w_alog.size() >= 2 && w_pc4_log.size() >= 2) begin
      chk("wrap_addr0", w_alog[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", w_alog[1], 32'h0000_0000);
      chk("wrap_pc4_0", w_pc4_log[0], 32'h0000_0000);
      chk("wrap_instr0", w_instr_log[0], 32'h2152_4113);
      chk("wrap_pc4_1", w_pc4_log[1], 32'h0000_0004);
    end else chk("wrap_counts", w_alog.size() + w_pc4_log.size(), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of prefetch buffer entries (power of two, at least 2).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  32  fetch address, word aligned.
REQ-008 imem_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_rvalid  input  1  response data valid; responses return in request order.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 branch_taken  input  1  redirect request from a later stage.
REQ-012 branch_target  input  32  redirect address.
REQ-013 stall  input  1  the decode stage cannot accept an instruction this cycle.
REQ-014 next_instruction  output  32  instruction presented to the decode stage.
REQ-015 pc_plus_4  output  32  address of the presented instruction plus 4.
REQ-016 inst_valid  output  1  next_instruction and pc_plus_4 are valid.

Function
REQ-017 A request SHALL be accepted only when imem_req and imem_ready are both high; imem_addr SHALL equal the PC register.
REQ-018 imem_req SHALL be high only when outstanding + fifo_count < FIFO_DEPTH and branch_taken is low, so that the buffer can never overflow.
REQ-019 On acceptance, the PC SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-020 A kept response SHALL be pushed into the FIFO together with resp_pc+4, and resp_pc SHALL then advance by 4.
REQ-021 inst_valid SHALL equal the FIFO-not-empty condition; next_instruction and pc_plus_4 SHALL come from the FIFO head.
REQ-022 The head SHALL be popped when inst_valid is high and stall is low; with no stall, latency from an accepted request to inst_valid SHALL be the memory latency plus 1 cycle.
REQ-023 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-024 When branch_taken is high:
- PC and resp_pc SHALL be loaded with {branch_target[31:2], 2'b00};
- the FIFO SHALL be flushed;
- discard_count SHALL be set to the outstanding count, excluding any response arriving in that same cycle, which SHALL itself be dropped;
- no request SHALL be issued that cycle.
REQ-025 branch_taken SHALL have priority over stall and over a pop in the same cycle.
REQ-026 While discard_count > 0, each arriving response SHALL be dropped and discard_count decremented; a branch arriving during discard SHALL reload discard_count per REQ-024.
REQ-027 When the FIFO is empty, next_instruction SHALL hold 32'h0000_0000 (NOP) and pc_plus_4 SHALL hold 0.
REQ-028 While stall is held, the presented instruction SHALL remain stable, and fetching SHALL continue until the credit limit is reached.

Reset
REQ-029 Reset assertion SHALL immediately set:
- PC and resp_pc = RESET_PC;
- FIFO empty;
- outstanding = 0 and discard_count = 0;
- inst_valid = 0, imem_req = 0, next_instruction = 0, pc_plus_4 = 0.
REQ-030 Responses for requests issued before reset SHALL NOT arrive after reset deassertion; this is a memory-side obligation.
REQ-031 The first request SHALL be issued in the first cycle after reset deasserts.

Structure
REQ-032 A shared package mips_pkg SHALL hold the NOP word, the 32-bit word width and the default RESET_PC constant.
REQ-033 The buffer SHALL be a sub-module fetch_fifo (synchronous push/pop/flush, count output), instantiated once.
REQ-034 The outstanding and discard counters SHALL each be clog2(FIFO_DEPTH)+1 bits wide.

Verification
REQ-035 Reset, imem_ready=1, 1-cycle memory, no stall -> imem_addr 0,4,8,...; inst_valid rises 2 cycles after the first accept; pc_plus_4 sequence 4,8,12.
REQ-036 stall held 5 cycles with the FIFO full -> imem_req=0, next_instruction stable; after release, in-order delivery with no duplicate or lost words.
REQ-037 branch_taken with branch_target=32'h0000_0103 while 2 requests are outstanding -> both responses dropped, next imem_addr=32'h100, first delivered pc_plus_4=32'h104.
REQ-038 branch_taken and stall in the same cycle with the FIFO non-empty -> FIFO flushed, inst_valid=0 next cycle.
REQ-039 RESET_PC=32'hFFFF_FFFC -> imem_addr sequence FFFF_FFFC then 0000_0000; pc_plus_4 of the first instruction = 0.
REQ-040 reset asserted mid-stream with the FIFO full -> outputs cleared asynchronously; after release, fetch restarts at RESET_PC.
